// File: rtl/debug_trace_buffer.sv
// Retirement trace buffer: circular capture of WB retirements, freeze after EIP trigger + post window,
// oldest-first drain over valid/ready. Optional macro DBG_TRACE_FLAGS_EN appends 7 eflags bits to entries.
module debug_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int EIP_W     = 32,
  parameter int DATA_W    = 64,
  parameter int CYC_W     = 16,
  parameter int POST_TRIG = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int CNT_W    = AW + 1,
`ifdef DBG_TRACE_FLAGS_EN
  localparam int ENT_W    = CYC_W + EIP_W + DATA_W + 7
`else
  localparam int ENT_W    = CYC_W + EIP_W + DATA_W
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wb_v,
  input  logic              wb_stall,
  input  logic [EIP_W-1:0]  wb_eip,
  input  logic [DATA_W-1:0] wb_result,
`ifdef DBG_TRACE_FLAGS_EN
  input  logic [6:0]        wb_eflags,
`endif
  input  logic              arm,
  input  logic              abort,
  input  logic [EIP_W-1:0]  trig_eip,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ENT_W-1:0]  rd_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_post;
  logic [CNT_W-1:0]   r_count;
  logic [ENT_W-1:0]   r_mem [DEPTH];

  logic               w_ret;
  logic               w_hit;
  logic               w_full;
  logic               w_capture;
  logic               w_load_post;
  logic               w_pop;
  logic               w_clear;
  logic [ENT_W-1:0]   w_entry;

  assign w_ret  = wb_v & ~wb_stall;
  assign w_hit  = (wb_eip == trig_eip);
  assign w_full = (r_count == CNT_W'(DEPTH));

`ifdef DBG_TRACE_FLAGS_EN
  assign w_entry = {r_cyc, wb_eip, wb_result, wb_eflags};
`else
  assign w_entry = {r_cyc, wb_eip, wb_result};
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_load_post = 1'b0;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            w_state_nxt = S_ARMED;
            w_clear     = 1'b1;
          end
        end
        S_ARMED: begin
          if (w_ret) begin
            w_capture = 1'b1;
            if (w_hit) begin
              w_load_post = 1'b1;
              w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          // Matches here are deliberately ignored: one trigger per arm.
          if (w_ret) begin
            w_capture = 1'b1;
            if (r_post == AW'(1)) w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_valid && rd_ready) begin
            w_pop = 1'b1;
            if (r_count == CNT_W'(1)) w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cyc    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_post   <= '0;
      r_count  <= '0;
    end else begin
      r_cyc <= r_cyc + CYC_W'(1);
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_post   <= '0;
        r_count  <= '0;
      end else begin
        if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          // A full buffer overwrites its oldest entry, so the read side slides along.
          if (w_full) r_rd_ptr <= r_rd_ptr + AW'(1);
          else        r_count  <= r_count + CNT_W'(1);
        end
        if (w_load_post) r_post <= AW'(POST_TRIG);
        else if (w_capture && r_state == S_POST) r_post <= r_post - AW'(1);
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_count  <= r_count - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the trace RAM is not reset; pointers and count define which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (w_capture) r_mem[r_wr_ptr] <= w_entry;
  end

  assign state_o  = r_state;
  assign count_o  = r_count;
  assign rd_valid = (r_state == S_DONE) && (r_count != '0);
  assign rd_data  = rd_valid ? r_mem[r_rd_ptr] : '0;

endmodule
